// File: rtl/lut_srl_cfg_pkg.sv
// Shared types and constants for the configurable LUT / SRL cell.
// The controller and the datapath both import this package.
package lut_srl_cfg_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int   K_DEF    = 4;
  localparam logic MODE_LUT = 1'b0;
  localparam logic MODE_SRL = 1'b1;

  function automatic int lut_depth(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/lut_srl_cfg_ctrl.sv
// Reload FSM and bit counter. Chooses the single shift source for the storage
// (SRL data or serial config bit) and produces the config handshake outputs.
module lut_srl_cfg_ctrl
  import lut_srl_cfg_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic mode,
  input  logic ce,
  input  logic di,
  input  logic cfg_start,
  input  logic cfg_valid,
  input  logic cfg_din,
  output logic shift_en,
  output logic shift_din,
  output logic cfg_ready,
  output logic cfg_done,
  output logic load_active
);

  localparam int             N        = lut_depth(K);
  localparam logic [K-1:0]   CNT_LAST = K'(N - 1);
  localparam logic [K-1:0]   CNT_ONE  = K'(1);

  state_t       state_reg, state_next;
  logic [K-1:0] cnt_reg, cnt_next;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_en    = 1'b0;
    shift_din   = di;
    cfg_ready   = 1'b0;
    cfg_done    = 1'b0;
    load_active = 1'b0;
    case (state_reg)
      ST_RUN: begin
        shift_en = (mode == MODE_SRL) && ce;
        if (cfg_start) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        cfg_ready   = 1'b1;
        load_active = 1'b1;
        if (cfg_valid) begin
          shift_en  = 1'b1;
          shift_din = cfg_din;
          // Counter wraps back to zero exactly when the last bit lands.
          cnt_next  = cnt_reg + CNT_ONE;
          if (cnt_reg == CNT_LAST) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cfg_done   = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule

// File: rtl/lut_srl_cfg.sv
// K-input LUT whose contents double as a 2^K-deep shift register and can be
// reloaded serially. O and CASC are combinational from storage.
module lut_srl_cfg
  import lut_srl_cfg_pkg::*;
#(
  parameter int               K    = K_DEF,
  parameter logic [(1<<K)-1:0] INIT = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [K-1:0] A,
  output logic         O,
  input  logic         MODE,
  input  logic         CE,
  input  logic         DI,
  output logic         CASC,
  input  logic         CFG_START,
  input  logic         CFG_VALID,
  input  logic         CFG_DIN,
  output logic         CFG_READY,
  output logic         CFG_DONE
);

  localparam int N = lut_depth(K);

  logic         shift_en;
  logic         shift_din;
  logic         load_active;
  logic [N-1:0] mem_reg;
  logic [N-1:0] mem_next;

  lut_srl_cfg_ctrl #(.K(K)) u_ctrl (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .mode       (MODE),
    .ce         (CE),
    .di         (DI),
    .cfg_start  (CFG_START),
    .cfg_valid  (CFG_VALID),
    .cfg_din    (CFG_DIN),
    .shift_en   (shift_en),
    .shift_din  (shift_din),
    .cfg_ready  (CFG_READY),
    .cfg_done   (CFG_DONE),
    .load_active(load_active)
  );

  // New bit enters at mem[0]; after a full load the first bit sits at mem[N-1].
  assign mem_next[0] = shift_din;
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
      assign mem_next[gi] = mem_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_reg <= INIT;
    end else if (shift_en) begin
      mem_reg <= mem_next;
    end
  end

  assign O    = load_active ? 1'b0 : mem_reg[A];
  assign CASC = mem_reg[N-1];

endmodule

// File: tb/tb_lut_srl_cfg.sv
// Self-checking bench: directed vectors for reset, loads, SRL and mid-load
// reset, then random stimulus against a bit-list reference model.
module tb_lut_srl_cfg;

  localparam logic [15:0] INIT_A = 16'hA5C3;

  logic       CLK;
  logic       RST_N;
  logic [3:0] A;
  logic       MODE, CE, DI;
  logic       CFG_START, CFG_VALID, CFG_DIN;
  logic       O_a, CASC_a, RDY_a, DONE_a;
  logic       O_z, CASC_z, RDY_z, DONE_z;

  int total = 0;
  int bad   = 0;

  lut_srl_cfg #(.K(4), .INIT(INIT_A)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .A(A), .O(O_a), .MODE(MODE), .CE(CE), .DI(DI),
    .CASC(CASC_a), .CFG_START(CFG_START), .CFG_VALID(CFG_VALID),
    .CFG_DIN(CFG_DIN), .CFG_READY(RDY_a), .CFG_DONE(DONE_a)
  );

  lut_srl_cfg #(.K(4), .INIT(16'h0000)) dut_z (
    .CLK(CLK), .RST_N(RST_N), .A(A), .O(O_z), .MODE(MODE), .CE(CE), .DI(DI),
    .CASC(CASC_z), .CFG_START(CFG_START), .CFG_VALID(CFG_VALID),
    .CFG_DIN(CFG_DIN), .CFG_READY(RDY_z), .CFG_DONE(DONE_z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the contents as a 16-bit word plus "loading / just
  // finished" flags and the number of config bits received so far.
  typedef struct {
    logic [15:0] bits;
    bit          loading;
    bit          finished;
    int          got;
  } mdl_t;

  mdl_t m_a, m_z;

  function automatic mdl_t mdl_init(input logic [15:0] iv);
    mdl_t s;
    s.bits = iv; s.loading = 0; s.finished = 0; s.got = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s);
    mdl_t n = s;
    if (s.finished) begin
      n.finished = 0;
    end else if (s.loading) begin
      if (CFG_VALID) begin
        n.bits = {s.bits[14:0], CFG_DIN};
        n.got  = s.got + 1;
        if (n.got == 16) begin
          n.loading  = 0;
          n.finished = 1;
        end
      end
    end else begin
      if (MODE && CE) n.bits = {s.bits[14:0], DI};
      if (CFG_START) begin
        n.loading = 1;
        n.got     = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    mdl_t na, nz;
    na = mdl_step(m_a);
    nz = mdl_step(m_z);
    @(posedge CLK);
    #1;
    m_a = na;
    m_z = nz;
  endtask

  task automatic idle_inputs();
    MODE = 0; CE = 0; DI = 0; CFG_START = 0; CFG_VALID = 0; CFG_DIN = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 0;
    m_a = mdl_init(INIT_A);
    m_z = mdl_init(16'h0000);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;
  endtask

  task automatic check_mem(input string nm, input bit z, input logic [15:0] e);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check(nm, z ? O_z : O_a, e[a]);
    end
  endtask

  // Serial load of pat; gap drops VALID every other cycle, noise drives CE,
  // MODE=SRL and a second CFG_START while loading.
  task automatic do_load(input logic [15:0] pat, input bit gap, input bit noise,
                         input int exp_done);
    int acc = 0;
    int done_cyc = -1;
    CFG_START = 1;
    cyc();
    CFG_START = 0;
    for (int c = 0; c < 80; c++) begin
      CFG_VALID = gap ? (c % 2 == 0) : 1'b1;
      CFG_DIN   = (acc < 16) ? pat[15 - acc] : 1'b0;
      CE        = noise;
      MODE      = noise;
      DI        = noise;
      CFG_START = noise && (c == 5);
      A         = 4'($urandom_range(0, 15));
      #1;
      if (DONE_a === 1'b1) begin
        done_cyc = c;
        break;
      end
      check("ld_ready", RDY_a, 1);
      check("ld_o_zero", O_a, 0);
      if (CFG_VALID) acc++;
      cyc();
    end
    check("ld_done_cycle", done_cyc, exp_done);
    check("ld_done_ready", RDY_a, 0);
    idle_inputs();
    cyc();
    check("ld_done_pulse_end", DONE_a, 0);
    $display("load pat=%04h gap=%0d noise=%0d done_cycle=%0d accepted=%0d",
             pat, gap, noise, done_cyc, acc);
  endtask

  typedef struct {
    logic [3:0] a;
    logic       o;
  } vec_t;

  vec_t rst_vec[5];
  vec_t ld_vec[3];

  initial begin
    RST_N = 1; A = 0;
    idle_inputs();
    rst_vec[0] = '{4'd0,  1'b1};
    rst_vec[1] = '{4'd2,  1'b0};
    rst_vec[2] = '{4'd15, 1'b1};
    rst_vec[3] = '{4'd6,  1'b1};
    rst_vec[4] = '{4'd9,  1'b0};
    ld_vec[0]  = '{4'd15, 1'b1};
    ld_vec[1]  = '{4'd0,  1'b1};
    ld_vec[2]  = '{4'd7,  1'b0};

    // Reset state
    do_reset();
    for (int i = 0; i < 5; i++) begin
      A = rst_vec[i].a;
      #1;
      check("rst_o", O_a, rst_vec[i].o);
      $display("rst vec A=%0d O=%0b", A, O_a);
    end
    check("rst_casc", CASC_a, 1);
    check("rst_ready", RDY_a, 0);
    check("rst_done", DONE_a, 0);

    // Back-to-back load of 8001
    do_load(16'h8001, 0, 0, 16);
    for (int i = 0; i < 3; i++) begin
      A = ld_vec[i].a;
      #1;
      check("ld8001_o", O_a, ld_vec[i].o);
    end
    check_mem("ld8001_mem", 0, 16'h8001);

    // Gapped load: idle cycles must not advance the count
    do_reset();
    do_load(16'h8001, 1, 0, 31);
    check_mem("gap_mem", 0, 16'h8001);

    // SRL shifting on the INIT=0 instance
    do_reset();
    MODE = 1; DI = 1; CE = 1;
    repeat (3) cyc();
    CE = 0;
    repeat (2) cyc();
    check_mem("srl_mem", 1, 16'h0007);
    A = 4'd2; #1; check("srl_a2", O_z, 1);
    A = 4'd3; #1; check("srl_a3", O_z, 0);
    check("srl_casc", CASC_z, 0);
    $display("srl shift3 hold2 done");

    do_reset();
    MODE = 0; DI = 1; CE = 1;
    repeat (3) cyc();
    CE = 0;
    repeat (2) cyc();
    check_mem("lut_hold_mem", 1, 16'h0000);

    // Reset in the middle of a load
    do_reset();
    CFG_START = 1;
    cyc();
    CFG_START = 0;
    CFG_VALID = 1;
    for (int i = 0; i < 7; i++) begin
      CFG_DIN = i[0];
      cyc();
    end
    RST_N = 0;
    m_a = mdl_init(INIT_A);
    m_z = mdl_init(16'h0000);
    check_mem("midrst_mem", 0, INIT_A);
    check("midrst_ready", RDY_a, 0);
    check("midrst_done", DONE_a, 0);
    @(posedge CLK);
    #1;
    RST_N = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("midrst_no_done", DONE_a, 0);
      check("midrst_run_ready", RDY_a, 0);
      cyc();
    end
    idle_inputs();
    $display("mid-load reset done");

    // Restart request and CE during load are ignored
    do_load(16'h3C5A, 0, 1, 16);
    check_mem("noise_mem", 0, 16'h3C5A);
    check_mem("noise_mem_z", 1, 16'h3C5A);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      MODE      = 1'($urandom_range(0, 1));
      CE        = 1'($urandom_range(0, 1));
      DI        = 1'($urandom_range(0, 1));
      CFG_START = ($urandom_range(0, 15) == 0);
      CFG_VALID = 1'($urandom_range(0, 1));
      CFG_DIN   = 1'($urandom_range(0, 1));
      A         = 4'($urandom_range(0, 15));
      #1;
      check("rnd_o_a",    O_a,    m_a.loading ? 1'b0 : m_a.bits[A]);
      check("rnd_casc_a", CASC_a, m_a.bits[15]);
      check("rnd_rdy_a",  RDY_a,  m_a.loading);
      check("rnd_done_a", DONE_a, m_a.finished);
      check("rnd_o_z",    O_z,    m_z.loading ? 1'b0 : m_z.bits[A]);
      check("rnd_casc_z", CASC_z, m_z.bits[15]);
      check("rnd_rdy_z",  RDY_z,  m_z.loading);
      check("rnd_done_z", DONE_z, m_z.finished);
      cyc();
    end
    $display("random phase done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
